// File: rtl/mips150_lsu_if.sv
// mips150_lsu_if: bundles the X-stage request, M-stage writeback/exceptions,
// DMEM/IMEM write ports and the IO bus of the MIPS150 load/store unit.
//   slave  : the LSU side (consumes x_*, memory read data and IO responses)
//   master : the pipeline/memory side (drives x_*, dmem_rdata, io_ready/rvalid/rdata)
interface mips150_lsu_if #(
  parameter int DMEM_AW = 12,
  parameter int IMEM_AW = 12
);
  // X stage request
  logic               x_valid;
  logic               x_store;
  logic [1:0]         x_size;
  logic               x_unsigned;
  logic [31:0]        x_addr;
  logic [31:0]        x_wdata;
  logic [4:0]         x_rd;
  logic               stall;
  // M stage result
  logic               m_wb_en;
  logic [4:0]         m_wb_reg;
  logic [31:0]        m_wb_data;
  logic               exc_misalign;
  logic               exc_buserr;
  // memories
  logic [3:0]         dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic [31:0]        dmem_rdata;
  logic [3:0]         imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_wdata;
  // IO bus
  logic               io_valid;
  logic               io_we;
  logic [3:0]         io_be;
  logic [31:0]        io_addr;
  logic [31:0]        io_wdata;
  logic               io_ready;
  logic               io_rvalid;
  logic [31:0]        io_rdata;

  modport slave (
    input  x_valid, x_store, x_size, x_unsigned, x_addr, x_wdata, x_rd,
    input  dmem_rdata, io_ready, io_rvalid, io_rdata,
    output stall, m_wb_en, m_wb_reg, m_wb_data, exc_misalign, exc_buserr,
    output dmem_we, dmem_addr, dmem_wdata, imem_we, imem_addr, imem_wdata,
    output io_valid, io_we, io_be, io_addr, io_wdata
  );

  modport master (
    output x_valid, x_store, x_size, x_unsigned, x_addr, x_wdata, x_rd,
    output dmem_rdata, io_ready, io_rvalid, io_rdata,
    input  stall, m_wb_en, m_wb_reg, m_wb_data, exc_misalign, exc_buserr,
    input  dmem_we, dmem_addr, dmem_wdata, imem_we, imem_addr, imem_wdata,
    input  io_valid, io_we, io_be, io_addr, io_wdata
  );
endinterface

// File: rtl/mips150_lsu.sv
// mips150_lsu: load/store unit for the MIPS150 pipeline.
//   X stage: region decode (DMEM/IMEM/IO by addr[31:28]), alignment and
//   legality checks, byte enables and replicated write data; DMEM/IMEM writes
//   are combinational in the accept cycle.
//   M stage: load data extraction/extension, writeback and exception pulses.
//   IO accesses run through a stalling IDLE->IO_REQ->(IO_RD)->IO_DONE
//   handshake with a cycle-count timeout that turns into a bus error.
// Ports: clk, rst (sync, active high), bus (mips150_lsu_if.slave).
module mips150_lsu #(
  parameter int       DMEM_AW    = 12,
  parameter int       IMEM_AW    = 12,
  parameter logic [3:0] DMEM_TAG = 4'h1,
  parameter logic [3:0] IMEM_TAG = 4'h2,
  parameter logic [3:0] IO_TAG   = 4'h8,
  parameter bit       BIG_ENDIAN = 1'b1,
  parameter int       TIMEOUT    = 16
) (
  input logic          clk,
  input logic          rst,
  mips150_lsu_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, IO_REQ, IO_RD, IO_DONE} state_e;

  // Byte enables for a given size/offset.
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] o);
    case (sz)
      2'b00:   lane_be = BIG_ENDIAN ? (4'b1000 >> o) : (4'b0001 << o);
      2'b01:   lane_be = (o[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Pick the addressed byte/half out of a word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic [1:0] o, input logic uns);
    logic [1:0]  lane;
    logic [7:0]  b;
    logic [15:0] h;
    lane = BIG_ENDIAN ? ~o : o;
    b    = w[{lane, 3'b000} +: 8];
    h    = (o[1] ^ BIG_ENDIAN) ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   extract = {{24{~uns & b[7]}}, b};
      2'b01:   extract = {{16{~uns & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q;

  // X-stage decode
  logic [1:0]  off;
  logic [3:0]  tag;
  logic        is_d, is_i, is_io, misalign, buserr, ok, accept, io_launch, do_write;
  logic [3:0]  be;
  logic [31:0] wrep;

  always_comb begin
    off      = bus.x_addr[1:0];
    tag      = bus.x_addr[31:28];
    is_d     = (tag == DMEM_TAG);
    is_i     = (tag == IMEM_TAG);
    is_io    = (tag == IO_TAG);
    misalign = ((bus.x_size == 2'b01) & off[0]) | ((bus.x_size == 2'b10) & (off != 2'b00));
    buserr   = ~misalign & ((bus.x_size == 2'b11) | ~(is_d | is_i | is_io) | (is_i & ~bus.x_store));
    ok       = ~misalign & ~buserr;
    // Only IDLE accepts: in IO_DONE the held instruction is the one just retired.
    accept    = bus.x_valid & (state_q == IDLE) & ~rst;
    io_launch = accept & ok & is_io;
    do_write  = accept & ok & bus.x_store;
    be        = lane_be(bus.x_size, off);
    case (bus.x_size)
      2'b00:   wrep = {4{bus.x_wdata[7:0]}};
      2'b01:   wrep = {2{bus.x_wdata[15:0]}};
      default: wrep = bus.x_wdata;
    endcase
  end

  assign bus.dmem_we    = (do_write & is_d) ? be : 4'b0000;
  assign bus.imem_we    = (do_write & is_i) ? be : 4'b0000;
  assign bus.dmem_addr  = bus.x_addr[DMEM_AW+1:2];
  assign bus.imem_addr  = bus.x_addr[IMEM_AW+1:2];
  assign bus.dmem_wdata = wrep;
  assign bus.imem_wdata = wrep;

  // IO request latches
  logic [31:0] io_addr_q, io_wdata_q, io_word_q;
  logic [3:0]  io_be_q;
  logic        io_we_q, io_uns_q, err_q;
  logic [1:0]  io_sz_q;
  logic [4:0]  io_rd_q;
  logic        cap, tmo, cnt_hit;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state. A response in the same cycle as the last timeout
  // cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    tmo     = 1'b0;
    cnt_hit = (cnt_q == CW'(TIMEOUT - 1));
    case (state_q)
      IDLE:   if (io_launch) state_d = IO_REQ;
      IO_REQ: begin
        if (bus.io_ready) begin
          if (io_we_q)            state_d = IO_DONE;
          else if (bus.io_rvalid) begin state_d = IO_DONE; cap = 1'b1; end
          else                    state_d = IO_RD;
        end else if (cnt_hit) begin
          state_d = IO_DONE; tmo = 1'b1;
        end
      end
      IO_RD: begin
        if (bus.io_rvalid)  begin state_d = IO_DONE; cap = 1'b1; end
        else if (cnt_hit)   begin state_d = IO_DONE; tmo = 1'b1; end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.stall    = ~rst & ((state_q == IO_REQ) | (state_q == IO_RD) | io_launch);
    bus.io_valid = (state_q == IO_REQ);
  end

  assign bus.io_we    = io_we_q;
  assign bus.io_be    = io_be_q;
  assign bus.io_addr  = io_addr_q;
  assign bus.io_wdata = io_wdata_q;

  // M-stage registers
  logic        m_ld_q, m_io_q, mis_q, bus_q, m_uns_q;
  logic [1:0]  m_sz_q, m_off_q;
  logic [4:0]  m_rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      io_addr_q <= '0; io_wdata_q <= '0; io_word_q <= '0; io_be_q <= '0;
      io_we_q <= 1'b0; io_uns_q <= 1'b0; io_sz_q <= '0; io_rd_q <= '0; err_q <= 1'b0;
      m_ld_q <= 1'b0; m_io_q <= 1'b0; mis_q <= 1'b0; bus_q <= 1'b0;
      m_uns_q <= 1'b0; m_sz_q <= '0; m_off_q <= '0; m_rd_q <= '0;
    end else begin
      m_ld_q <= 1'b0;
      m_io_q <= 1'b0;
      mis_q  <= 1'b0;
      bus_q  <= 1'b0;
      if (io_launch) begin
        cnt_q      <= '0;
        err_q      <= 1'b0;
        io_addr_q  <= bus.x_addr;
        io_wdata_q <= wrep;
        io_be_q    <= be;
        io_we_q    <= bus.x_store;
        io_sz_q    <= bus.x_size;
        io_uns_q   <= bus.x_unsigned;
        io_rd_q    <= bus.x_rd;
      end else if (state_q == IO_REQ || state_q == IO_RD) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (cap) io_word_q <= bus.io_rdata;
      if (tmo) err_q     <= 1'b1;
      if (accept) begin
        mis_q <= misalign;
        bus_q <= buserr;
        if (ok & is_d & ~bus.x_store) begin
          m_ld_q  <= 1'b1;
          m_rd_q  <= bus.x_rd;
          m_sz_q  <= bus.x_size;
          m_off_q <= off;
          m_uns_q <= bus.x_unsigned;
        end
      end
      // IO completion reports in the cycle after IO_DONE.
      if (state_q == IO_DONE) begin
        bus_q <= err_q;
        if (~err_q & ~io_we_q) begin
          m_io_q  <= 1'b1;
          m_rd_q  <= io_rd_q;
          m_sz_q  <= io_sz_q;
          m_off_q <= io_addr_q[1:0];
          m_uns_q <= io_uns_q;
        end
      end
    end
  end

  logic wb_en;
  assign wb_en            = (m_ld_q | m_io_q) & (m_rd_q != 5'd0);
  assign bus.m_wb_en      = wb_en;
  assign bus.m_wb_reg     = wb_en ? m_rd_q : 5'd0;
  assign bus.m_wb_data    = wb_en ? extract(m_io_q ? io_word_q : bus.dmem_rdata,
                                            m_sz_q, m_off_q, m_uns_q) : 32'd0;
  assign bus.exc_misalign = mis_q;
  assign bus.exc_buserr   = bus_q;
endmodule
